sub_bytes_pipe: RTL and testbench

Parametrised, pipelined AES SubBytes engine. Each beat substitutes LANES bytes in parallel through either the forward AES S-box or the inverse S-box, selected per beat. It replaces single-byte combinational lookups in the cipher datapath. It gives the round logic a registered, flow-controlled stage with a valid/ready handshake on both sides.

---
 rtl/sub_bytes_if.sv | 27 ++
 rtl/sub_bytes_pipe.sv | 117 +++++++++++
 tb/tb_sub_bytes_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_bytes_if.sv
// Beat-level handshake bundle for the SubBytes engine: input channel, output channel
// and the per-beat mode bit.
interface sub_bytes_if #(
  parameter int unsigned LANES = 16
) ();
  localparam int unsigned DW = 8 * LANES;

  logic          in_valid;
  logic          in_ready;
  logic          in_inv;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_inv;

  // master drives beats in and accepts results; slave is the engine
  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inv
  );

  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inv
  );
endinterface

// File: rtl/sub_bytes_pipe.sv
// Two-stage, flow-controlled AES SubBytes engine: LANES bytes per beat through the
// forward or inverse S-box, mode travelling with each beat.
module sub_bytes_pipe #(
  parameter int unsigned LANES = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  sub_bytes_if.slave       bus,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);
  localparam int unsigned DW = 8 * LANES;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  // One field inverter per lane shared by both directions
  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    logic [7:0] pre;
    logic [7:0] mid;
    pre = inv ? inv_affine(b) : b;
    mid = gf_inv(pre);
    return inv ? mid : fwd_affine(mid);
  endfunction

  logic          r_s1_valid;
  logic          r_s1_inv;
  logic [DW-1:0] r_s1_data;
  logic          r_s2_valid;
  logic          r_s2_inv;
  logic [DW-1:0] r_s2_data;
  logic [CNT_W-1:0] r_beat_cnt;

  logic          w_s2_adv;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_s1_move;
  logic          w_deliver;
  logic [DW-1:0] w_sub;

  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_s1_move  = r_s1_valid && w_s2_adv;
  assign w_deliver  = r_s2_valid && bus.out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_sub[8*g +: 8] = sub_byte(r_s1_data[8*g +: 8], r_s1_inv);
  end

  // Data/mode registers load only on transfer so a stalled output stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_inv   <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_inv   <= 1'b0;
      r_s2_data  <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_in_ready) r_s1_valid <= bus.in_valid;
      if (w_accept) begin
        r_s1_data <= bus.in_data;
        r_s1_inv  <= bus.in_inv;
      end
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s1_move) begin
        r_s2_data <= w_sub;
        r_s2_inv  <= r_s1_inv;
      end
      if (w_deliver) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.out_inv   = r_s2_inv;
  assign busy          = r_s1_valid || r_s2_valid;
  assign beat_cnt      = r_beat_cnt;
endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Scoreboard bench for sub_bytes_pipe: S-box reference tables are generated from the
// GF(2^8) generator walk, independent of the engine's inversion datapath.
module tb_sub_bytes_pipe;
  localparam int unsigned LANES = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 8 * LANES;
  localparam int          CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] beat_cnt;

  sub_bytes_if #(.LANES(LANES)) bus ();

  sub_bytes_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int dlv    = 0;
  int cyc    = 0;
  int rdy_mode = 0;

  logic [7:0]  fwd_tab [256];
  logic [7:0]  inv_tab [256];
  logic [DW:0] sb_q [$];
  logic [DW:0] got_q [$];
  int          got_cyc [$];
  logic [DW-1:0] fwd_out [256];

  task automatic chk(input string name, input logic [DW:0] got, input logic [DW:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Walk the multiplicative group: p steps by 3, q by 1/3, so q = 1/p
  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      fwd_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_tab[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++)
      r[8*k +: 8] = inv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [DW-1:0] pat(input int v);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[8*k +: 8] = 8'(v + k);
    return r;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[8*k +: 8] = b;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output ready pattern: 0 = always ready, 1 = stalled, 2 = random
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: the head of the scoreboard must be presented whenever out_valid is high
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", {bus.out_inv, bus.out_data}, '0);
        if ({bus.out_inv, bus.out_data} == '0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got zero beat expected none (t=%0t)", $time);
        end
      end else begin
        chk("out_beat", {bus.out_inv, bus.out_data}, sb_q[0]);
        if (bus.out_ready) begin
          chk("beat_cnt_run", (DW+1)'(beat_cnt), (DW+1)'(dlv % CMOD));
          got_q.push_back({bus.out_inv, bus.out_data});
          got_cyc.push_back(cyc);
          void'(sb_q.pop_front());
          dlv++;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic inv, input logic [DW-1:0] exp);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_inv   = inv;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 1000) break;
    end
    if (n > 1000) begin
      chk("accept_timeout", (DW+1)'(n), '0);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb_q.push_back({inv, exp});
      acc_cnt++;
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_budget", (DW+1)'(n < 5000), (DW+1)'(1));
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_in_budget", (DW+1)'(n < 5000), (DW+1)'(1));
  endtask

  initial begin
    logic [DW-1:0] b0;
    int base;
    int dbase;
    bus.in_valid = 1'b0;
    bus.in_inv   = 1'b0;
    bus.in_data  = '0;
    build_tables();

    // Reset / idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", (DW+1)'(bus.out_valid), '0);
    chk("rst_out_data",  {bus.out_inv, bus.out_data}, '0);
    chk("rst_busy",      (DW+1)'(busy), '0);
    chk("rst_beat_cnt",  (DW+1)'(beat_cnt), '0);
    #2 rst = 1'b0;
    #1 chk("idle_in_ready", (DW+1)'(bus.in_ready), (DW+1)'(1));

    // Single forward beat: latency and known-answer lanes
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_inv   = 1'b0;
    bus.in_data  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    @(posedge clk);
    sb_q.push_back({1'b0, model(bus.in_data, 1'b0)});
    acc_cnt++;
    #1 bus.in_valid = 1'b0;
    chk("lat_edge1_valid", (DW+1)'(bus.out_valid), '0);
    @(posedge clk);
    #1;
    chk("lat_edge2_valid", (DW+1)'(bus.out_valid), (DW+1)'(1));
    chk("kat_fwd_0f", {bus.out_inv, bus.out_data}, {1'b0, 128'h76ABD7FE_2B670130_C56F6BF2_7B777C63});
    @(posedge clk);
    #1;
    chk("single_beat_cnt", (DW+1)'(beat_cnt), (DW+1)'(1));
    chk("single_idle_busy", (DW+1)'(busy), '0);

    // Mode alternation, back to back
    got_q.delete();
    got_cyc.delete();
    send(fill(8'h53), 1'b0, model(fill(8'h53), 1'b0));
    send(fill(8'h63), 1'b1, model(fill(8'h63), 1'b1));
    send(fill(8'hFF), 1'b0, model(fill(8'hFF), 1'b0));
    send(fill(8'h16), 1'b1, model(fill(8'h16), 1'b1));
    drain();
    chk("alt_count", (DW+1)'(got_q.size()), (DW+1)'(4));
    if (got_q.size() == 4) begin
      chk("alt_fwd_53", got_q[0], {1'b0, fill(8'hED)});
      chk("alt_inv_63", got_q[1], {1'b1, fill(8'h00)});
      chk("alt_fwd_ff", got_q[2], {1'b0, fill(8'h16)});
      chk("alt_inv_16", got_q[3], {1'b1, fill(8'hFF)});
      for (int i = 1; i < 4; i++)
        chk("alt_consecutive", (DW+1)'(got_cyc[i] - got_cyc[0]), (DW+1)'(i));
    end

    // Backpressure: stalled output holds beat 0 and throttles input after two accepts
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    base  = acc_cnt;
    dbase = dlv;
    b0    = pat(8'h40);
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(pat(8'h40 + 16 * i), 1'(i), model(pat(8'h40 + 16 * i), 1'(i)));
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    chk("bp_accepts", (DW+1)'(acc_cnt - base), (DW+1)'(2));
    chk("bp_in_ready", (DW+1)'(bus.in_ready), '0);
    chk("bp_hold_beat0", {bus.out_valid, bus.out_data}, {1'b1, model(b0, 1'b0)});
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_beat0", {bus.out_valid, bus.out_data}, {1'b1, model(b0, 1'b0)});
    rdy_mode = 0;
    wait_acc(base + 5);
    drain();
    chk("bp_delivered", (DW+1)'(dlv - dbase), (DW+1)'(5));
    chk("bp_beat_cnt", (DW+1)'(beat_cnt), (DW+1)'(dlv % CMOD));

    // Exhaustive both modes with random backpressure, then round trip of the forward results
    rdy_mode = 2;
    got_q.delete();
    for (int v = 0; v < 256; v++) begin
      send(pat(v), 1'b0, model(pat(v), 1'b0));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    drain();
    chk("exh_fwd_count", (DW+1)'(got_q.size()), (DW+1)'(256));
    for (int v = 0; v < 256; v++)
      fwd_out[v] = (v < got_q.size()) ? got_q[v][DW-1:0] : '0;
    for (int v = 0; v < 256; v++) begin
      send(pat(v), 1'b1, model(pat(v), 1'b1));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    for (int v = 0; v < 256; v++) send(fwd_out[v], 1'b1, pat(v));
    drain();

    // Reset with both stages full discards everything
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    base = acc_cnt;
    fork
      begin
        send(pat(8'hA0), 1'b0, model(pat(8'hA0), 1'b0));
        send(pat(8'hB0), 1'b1, model(pat(8'hB0), 1'b1));
      end
    join_none
    wait_acc(base + 2);
    @(negedge clk);
    chk("full_before_rst", {busy, bus.out_valid, bus.in_ready}, (DW+1)'(3'b110));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", (DW+1)'(bus.out_valid), '0);
    chk("mid_rst_busy", (DW+1)'(busy), '0);
    chk("mid_rst_beat_cnt", (DW+1)'(beat_cnt), '0);
    sb_q.delete();
    got_q.delete();
    dlv = 0;
    rdy_mode = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("post_rst_in_ready", (DW+1)'(bus.in_ready), (DW+1)'(1));
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale_beat", (DW+1)'(got_q.size()), '0);
    chk("post_rst_idle", {busy, bus.out_valid}, '0);
    chk("final_sb_empty", (DW+1)'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
